// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: md_op codes used by
// the decoder and the E stage, plus the combinational HI/LO result helper.
package md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic md_is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic md_result_t md_compute(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t        r;
    logic [63:0]       prod;
    logic              s_div_ok;
    logic [31:0]       s_divisor;
    logic [31:0]       u_divisor;
    logic signed [31:0] s_quot;
    logic signed [31:0] s_rem;

    r    = '0;
    prod = '0;
    // Divide by zero and 0x80000000 / -1 both get divisor 1: the zero case is
    // never committed, and the overflow case then yields lo=0x80000000, hi=0.
    s_div_ok  = (b != 32'd0) && !((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    s_divisor = s_div_ok ? b : 32'd1;
    u_divisor = (b != 32'd0) ? b : 32'd1;
    s_quot    = $signed(a) / $signed(s_divisor);
    s_rem     = $signed(a) % $signed(s_divisor);

    case (op)
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      MD_DIV: begin
        r.lo = s_quot;
        r.hi = s_rem;
      end
      MD_DIVU: begin
        r.lo = a / u_divisor;
        r.hi = a % u_divisor;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div with a fixed busy
// window, single-cycle mthi/mtlo, and the architectural HI/LO registers.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_commit;
  md_result_t       result;
  logic             is_mult;
  logic             is_div;

  // The full 64-bit result is computed at the start edge; the busy window only
  // models the latency the pipeline must respect.
  always_comb begin
    result  = md_compute(md_op, rs_data, rt_data);
    is_mult = md_is_mult(md_op);
    is_div  = md_is_div(md_op);
  end

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      pend_hi     <= '0;
      pend_lo     <= '0;
      pend_commit <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        if (is_mult || is_div) begin
          state       <= ST_RUN;
          count       <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_hi     <= result.hi;
          pend_lo     <= result.lo;
          pend_commit <= !(is_div && (rt_data == 32'd0));
        end else if (md_op == MD_MTHI) begin
          hi <= rs_data;
        end else if (md_op == MD_MTLO) begin
          lo <= rs_data;
        end
      end
    end else begin
      // Any start while running is dropped; only the countdown matters here.
      count <= count - 1'b1;
      if (count == CNT_W'(1)) begin
        state <= ST_IDLE;
        if (pend_commit) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: an edge-indexed behavioural model compared
// every cycle, plus directed vectors with hand-computed HI/LO and busy lengths.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        commit;
  } mres_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Plain 64-bit arithmetic; the 0x80000000 / -1 case needs no special handling here.
  function automatic mres_t model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mres_t       r;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    r.hi = '0; r.lo = '0; r.commit = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      OP_DIV:   if (b == 32'd0) r.commit = 1'b0;
                else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
      OP_DIVU:  if (b == 32'd0) r.commit = 1'b0;
                else begin r.lo = a / b; r.hi = a % b; end
      default:  r.commit = 1'b0;
    endcase
    return r;
  endfunction

  // Model: an accepted op at edge s keeps busy up to edge s+N, where HI/LO commit.
  int    edges;
  int    m_end;
  logic  m_busy;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  mres_t m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges <= 0; m_end <= 0; m_busy <= 1'b0; m_hi <= '0; m_lo <= '0; m_pend <= '0;
    end else begin
      edges <= edges + 1;
      if (m_busy) begin
        if (edges + 1 == m_end) begin
          m_busy <= 1'b0;
          if (m_pend.commit) begin m_hi <= m_pend.hi; m_lo <= m_pend.lo; end
        end
      end else if (start) begin
        case (md_op)
          OP_MULT, OP_MULTU: begin
            m_busy <= 1'b1; m_end <= edges + 1 + MULT_N; m_pend <= model_calc(md_op, rs_data, rt_data);
          end
          OP_DIV, OP_DIVU: begin
            m_busy <= 1'b1; m_end <= edges + 1 + DIV_N; m_pend <= model_calc(md_op, rs_data, rt_data);
          end
          OP_MTHI: m_hi <= rs_data;
          OP_MTLO: m_lo <= rs_data;
          default: ;
        endcase
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model busy", {31'd0, busy}, {31'd0, m_busy});
      check_output("model hi", hi, m_hi);
      check_output("model lo", lo, m_lo);
    end
  end

  // Presents one start for exactly one rising edge; returns in cycle 1 after it.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b;
    @(negedge clk); #1;
    start = 1'b0; md_op = OP_NONE; rs_data = '0; rt_data = '0;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      @(negedge clk); #1;
    end
    check_output(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    apply_stimulus(op, a, b);
    wait_idle({name, " busy len"}, n);
    check_output({name, " hi"}, hi, exp_hi);
    check_output({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit hit, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; md_op = OP_NONE; rs_data = '0; rt_data = '0;
    #2;
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;

    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_N, 32'd1, 32'hFFFF_FFFD);
    run_op("divu max/2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, DIV_N, 32'd1, 32'h7FFF_FFFF);
    run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

    apply_stimulus(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    check_output("mthi busy", {31'd0, busy}, 32'd0);
    check_output("mthi hi", hi, 32'hDEAD_BEEF);
    apply_stimulus(OP_MTHI, 32'h11, 32'd0);
    apply_stimulus(OP_MTLO, 32'h22, 32'd0);
    check_output("mtlo lo", lo, 32'h22);
    run_op("divu by 0", OP_DIVU, 32'd9, 32'd0, DIV_N, 32'h11, 32'h22);
    run_op("div by 0", OP_DIV, 32'hFFFF_FFF0, 32'd0, DIV_N, 32'h11, 32'h22);

    apply_stimulus(OP_NONE, 32'h1234, 32'h5678);
    apply_stimulus(3'd7, 32'h1234, 32'h5678);
    check_output("undef op busy", {31'd0, busy}, 32'd0);
    check_output("undef op lo", lo, 32'h22);

    apply_stimulus(OP_MULT, 32'd6, 32'd7);
    apply_stimulus(OP_MTLO, 32'h5555_5555, 32'd0);
    apply_stimulus(OP_MTHI, 32'hAAAA_AAAA, 32'd0);
    wait_idle("mt during run busy len", MULT_N - 2);
    check_output("mt during run hi", hi, 32'd0);
    check_output("mt during run lo", lo, 32'd42);

    apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_output("async reset busy", {31'd0, busy}, 32'd0);
    check_output("async reset hi", hi, 32'd0);
    check_output("async reset lo", lo, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    run_op("multu 2*3", OP_MULTU, 32'd2, 32'd3, MULT_N, 32'd0, 32'd6);

    run_op("mult 2^16*2^16", OP_MULT, 32'h0001_0000, 32'h0001_0000, MULT_N, 32'd1, 32'd0);
    run_op("b2b div 100/7", OP_DIV, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit with HI/LO registers. It consumes the operands and decoded operation that the decode/execute pipeline register presents to the E stage. It runs multi-cycle mult/multu/div/divu and single-cycle mthi/mtlo. It drives `busy` back to the hazard logic, which holds and bubbles the D/E boundary while an operation is outstanding.

## Interface
- `MULT_CYCLES`, default 5: cycles `busy` stays high after a mult/multu start.
- `DIV_CYCLES`, default 10: cycles `busy` stays high after a div/divu start.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  E-stage instruction is a mult/div-class op; qualifies `md_op`.
- `md_op`  in  3  operation code: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `rs_data`  in  32  forwarded rs operand (dividend / multiplicand / mt source).
- `rt_data`  in  32  forwarded rt operand (divisor / multiplier).
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, internal counter=0, pending results=0.
- Two states:
  - IDLE (`busy`=0).
  - RUN (`busy`=1, counter>0).
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU at a rising edge:
  - Compute the 64-bit result from `rs_data`/`rt_data` into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Enter RUN.
- IDLE, `start`=1, op MTHI/MTLO: write `rs_data` to `hi`/`lo` at that edge. No busy cycle.
- RUN: the counter decrements each edge. At the edge where the counter goes 1→0:
  - Commit pending values to `hi`/`lo`.
  - Return to IDLE.
- `start` while RUN is ignored entirely, including MTHI/MTLO. The hazard unit guarantees that no such start reaches E. The bench checks that one is ignored anyway.
- `start`=1 with `md_op`=NONE or an undefined code: no effect.
- Arithmetic rules:
  - MULT: signed 32×32→64; `hi`=product[63:32], `lo`=product[31:0].
  - MULTU: unsigned 32×32→64, same split.
  - DIV: signed; quotient truncates toward zero into `lo`; remainder into `hi`, carrying the sign of the dividend.
  - DIV overflow, 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - DIVU: unsigned quotient into `lo`, remainder into `hi`.
- Divide by zero (div or divu): full DIV_CYCLES busy period, then `hi`/`lo` stay unchanged at commit.
- A pipeline flush of the E stage does not cancel an operation already in RUN. Only `reset` does.

## Timing
- Start edge at cycle 0: `busy` reads 1 during cycles 1..N (N = MULT_CYCLES or DIV_CYCLES).
- `hi`/`lo` update at the edge ending cycle N, which is the same edge `busy` falls. They are readable in cycle N+1.
- MTHI/MTLO: new value is visible the cycle after the start edge.
- `busy` is a registered output; it never rises combinationally from `start`.
- Read hazards (mfhi/mflo, or a new md op, in D) must be covered externally by a stall condition of `start | busy`.
- Reset asserted mid-RUN, asynchronously:
  - `busy`, `hi`, `lo`, counter and pending results clear at once.
  - The first start is accepted on the first rising edge after `reset` deasserts.
- `hi`/`lo` hold their values across all cycles without a commit or mt write.

## Structure
- Add the `md_op` code constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) to the shared definitions include used by the decoder and the E stage.
- The decoder produces `start`/`md_op`; this block never decodes raw instruction bits.
- Single module: a counter/state register, pending HI/LO registers, and combinational mult/div result logic.
- No sub-module is needed.
- Behavioural `*` and `/`/`%` are acceptable. The signed-division corner cases above must be handled explicitly.

## Test plan
- MULT, rs=0xFFFFFFFD (−3), rt=5 → `busy` high exactly cycles 1–5; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIVU, rs=7, rt=2 → `busy` high cycles 1–10; then `lo`=3, `hi`=1. DIV, rs=−7, rt=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV, 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0. DIVU by 0 with prior hi=0x11, lo=0x22 → 10 busy cycles, then hi/lo still 0x11/0x22.
- MTHI rs=0xDEADBEEF in IDLE → `hi`=0xDEADBEEF next cycle, `busy` stays 0. MTLO issued during a MULT RUN → ignored, and `lo` shows only the MULT result.
- MULTU 0xFFFFFFFF×0xFFFFFFFF started, then `reset` pulsed in cycle 3 → `busy`/`hi`/`lo` =0 immediately. A MULTU 2×3 started after release → `lo`=6, `hi`=0 after 5 cycles.
- Back-to-back: MULT committed, then DIV started on the cycle after `busy` falls → accepted. DIV results overwrite the MULT values 10 cycles later.
